chain_paren_traceback: RTL and testbench

Reads back the split table filled in by the chain-multiplier min/argmin datapath, where s[i][j] is the best split k, and emits the optimal parenthesization as a token stream. It uses an explicit segment stack to walk the split tree depth-first and fetches s[i][j] from the split-table RAM through a one-cycle-latency read port. Tokens leave on a valid/ready interface toward the host or debug output. It sits after the DP fill controller and starts only once the table is complete.

---
 rtl/chain_paren_traceback.sv | 234 +++++++++++++++++++++++
 tb/tb_chain_paren_traceback.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_paren_traceback.sv
// chain_paren_traceback
//
// Walks the split table left behind by the chain-multiplier DP fill and
// emits the optimal parenthesization as a token stream. The split tree is
// walked depth-first with an explicit segment stack. s[i][j] comes from the
// split-table RAM through a read port with one cycle of latency.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, n            begin a traceback of an n-matrix chain (sampled in IDLE)
//   busy                traceback in progress
//   done                one-cycle pulse on normal completion
//   err                 one-cycle pulse on a rejected start or an invalid split
//   s_rd_en/i/j         split-table read strobe and address
//   s_rd_data           split value, valid the cycle after s_rd_en
//   tok_valid/ready     token handshake toward the consumer
//   tok_type, tok_idx   00 = M[tok_idx], 01 = '(', 10 = ')'
module chain_paren_traceback #(
  parameter int N_MAX = 16,
  parameter int IDX_W = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             s_rd_en,
  output logic [IDX_W-1:0] s_rd_i,
  output logic [IDX_W-1:0] s_rd_j,
  input  logic [DW-1:0]    s_rd_data,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_type,
  output logic [IDX_W-1:0] tok_idx
);

  // A full left/right-skewed tree leaves at most 2*N_MAX-1 entries pending.
  localparam int DEPTH = 2 * N_MAX - 1;
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int ENT_W = 1 + 2 * IDX_W;

  localparam logic       KIND_SEG   = 1'b0;
  localparam logic       KIND_CLOSE = 1'b1;
  localparam logic [1:0] TOK_MAT    = 2'b00;
  localparam logic [1:0] TOK_OPEN   = 2'b01;
  localparam logic [1:0] TOK_CLOSE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_EMIT,
    S_READ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0] cur_i_q, cur_i_d;
  logic [IDX_W-1:0] cur_j_q, cur_j_d;
  logic             expand_q, expand_d;
  logic [1:0]       tok_type_q, tok_type_d;
  logic [IDX_W-1:0] tok_idx_q, tok_idx_d;

  // Stack entries are {kind, i, j}; sp_q counts occupied entries.
  logic [ENT_W-1:0] stack_q [DEPTH];

  // Up to three pushes per cycle, written to slots sp, sp+1, sp+2.
  logic [2:0]              wr_en;
  logic [2:0][ENT_W-1:0]   wr_data;

  logic [ENT_W-1:0] top_ent;
  logic             top_kind;
  logic [IDX_W-1:0] top_i, top_j;
  logic [IDX_W-1:0] split_k;
  logic             n_ok, k_ok;
  logic             unused_rd_bits;

  assign top_ent  = stack_q[sp_q - SP_W'(1)];
  assign top_kind = top_ent[ENT_W-1];
  assign top_i    = top_ent[2*IDX_W-1:IDX_W];
  assign top_j    = top_ent[IDX_W-1:0];

  assign split_k        = s_rd_data[IDX_W-1:0];
  assign unused_rd_bits = ^s_rd_data[DW-1:IDX_W];

  assign n_ok = (n != '0) && (n <= IDX_W'(N_MAX));
  // A usable split must leave both halves non-empty: i <= k < j.
  assign k_ok = (split_k >= cur_i_q) && (split_k < cur_j_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      cur_i_q    <= '0;
      cur_j_q    <= '0;
      expand_q   <= 1'b0;
      tok_type_q <= '0;
      tok_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      cur_i_q    <= cur_i_d;
      cur_j_q    <= cur_j_d;
      expand_q   <= expand_d;
      tok_type_q <= tok_type_d;
      tok_idx_q  <= tok_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (rst) begin
        stack_q[e] <= '0;
      end else if (wr_en[0] && (sp_q == SP_W'(e))) begin
        stack_q[e] <= wr_data[0];
      end else if (wr_en[1] && ((sp_q + SP_W'(1)) == SP_W'(e))) begin
        stack_q[e] <= wr_data[1];
      end else if (wr_en[2] && ((sp_q + SP_W'(2)) == SP_W'(e))) begin
        stack_q[e] <= wr_data[2];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    cur_i_d    = cur_i_q;
    cur_j_d    = cur_j_q;
    expand_d   = expand_q;
    tok_type_d = tok_type_q;
    tok_idx_d  = tok_idx_q;
    wr_en      = '0;
    wr_data    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    s_rd_en    = 1'b0;
    s_rd_i     = '0;
    s_rd_j     = '0;
    tok_valid  = 1'b0;
    tok_type   = '0;
    tok_idx    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_ok) begin
            // Stack is always empty in IDLE, so the root lands in slot 0.
            wr_en[0]   = 1'b1;
            wr_data[0] = {KIND_SEG, IDX_W'(1), n};
            sp_d       = SP_W'(1);
            state_d    = S_POP;
          end else begin
            err = 1'b1;
          end
        end
      end

      S_POP: begin
        busy = 1'b1;
        if (sp_q == '0) begin
          state_d = S_DONE;
        end else begin
          sp_d    = sp_q - SP_W'(1);
          cur_i_d = top_i;
          cur_j_d = top_j;
          state_d = S_EMIT;
          if (top_kind == KIND_CLOSE) begin
            tok_type_d = TOK_CLOSE;
            tok_idx_d  = '0;
          end else if (top_i == top_j) begin
            tok_type_d = TOK_MAT;
            tok_idx_d  = top_i;
          end else begin
            tok_type_d = TOK_OPEN;
            tok_idx_d  = '0;
            expand_d   = 1'b1;
          end
        end
      end

      S_EMIT: begin
        busy      = 1'b1;
        tok_valid = 1'b1;
        tok_type  = tok_type_q;
        tok_idx   = tok_idx_q;
        if (tok_ready) begin
          state_d = expand_q ? S_READ : S_POP;
        end
      end

      S_READ: begin
        busy    = 1'b1;
        s_rd_en = 1'b1;
        s_rd_i  = cur_i_q;
        s_rd_j  = cur_j_q;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        busy     = 1'b1;
        expand_d = 1'b0;
        if (k_ok) begin
          // Push order leaves the left half on top, then the right half,
          // then the matching ')'.
          wr_en      = 3'b111;
          wr_data[0] = {KIND_CLOSE, cur_i_q, cur_j_q};
          wr_data[1] = {KIND_SEG, split_k + IDX_W'(1), cur_j_q};
          wr_data[2] = {KIND_SEG, cur_i_q, split_k};
          sp_d       = sp_q + SP_W'(3);
          state_d    = S_POP;
        end else begin
          err     = 1'b1;
          sp_d    = '0;
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chain_paren_traceback.sv
module tb_chain_paren_traceback;
  localparam int IDX_W = 5;
  localparam int DW    = 32;
  localparam int T_OPEN  = 32;   // {2'b01, 5'd0}
  localparam int T_CLOSE = 64;   // {2'b10, 5'd0}

  logic             clk, rst, start;
  logic [IDX_W-1:0] n;
  logic             busy, done, err, s_rd_en, tok_valid, tok_ready;
  logic [IDX_W-1:0] s_rd_i, s_rd_j, tok_idx;
  logic [DW-1:0]    s_rd_data;
  logic [1:0]       tok_type;

  chain_paren_traceback #(.N_MAX(16), .IDX_W(IDX_W), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .busy(busy), .done(done), .err(err),
    .s_rd_en(s_rd_en), .s_rd_i(s_rd_i), .s_rd_j(s_rd_j), .s_rd_data(s_rd_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_type(tok_type), .tok_idx(tok_idx)
  );

  logic [DW-1:0] tbl [0:31][0:31];

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int exp_tok[$], exp_rd[$], got_q[$], got_rd[$], want[$], ref_q[$];
  int rel, stalls, cur_n, exp_err_rel, rdy_mode;
  bit mon_en, exp_done, seen_done, seen_err, prev_stall;
  logic [1:0]       prev_type;
  logic [IDX_W-1:0] prev_idx;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Split-table RAM: data valid one cycle after the read strobe.
  always @(posedge clk) s_rd_data <= s_rd_en ? tbl[s_rd_i][s_rd_j] : '0;

  // Consumer: 0 = always ready, 1 = random ready, other = never ready.
  initial begin
    tok_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tok_ready = 1'b1;
        1:       tok_ready = 1'($urandom_range(0, 1));
        default: tok_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    cmp_cnt++;
    if (!ok) begin
      mis_cnt++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_tbl();
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        tbl[a][b] = '0;
  endtask

  // Reference: enumerate the split tree breadth-first, count how many
  // internal segments open at / close at each matrix, and lay the tokens out
  // matrix by matrix. Reads happen in preorder, i.e. by (i asc, j desc).
  task automatic build_model(input int nn);
    int segq[$];
    int opens[0:32];
    int closes[0:32];
    bit internal[0:32][0:32];
    int s, i, j, k;
    exp_tok.delete();
    exp_rd.delete();
    for (int a = 0; a < 33; a++) begin
      opens[a] = 0;
      closes[a] = 0;
      for (int b = 0; b < 33; b++) internal[a][b] = 1'b0;
    end
    segq.push_back(64 + nn);
    while (segq.size() > 0) begin
      s = segq.pop_front();
      i = s / 64;
      j = s % 64;
      if (i < j) begin
        k = int'(tbl[i][j][IDX_W-1:0]);
        if (k < i || k >= j) k = i;
        opens[i]++;
        closes[j]++;
        internal[i][j] = 1'b1;
        segq.push_back(i * 64 + k);
        segq.push_back((k + 1) * 64 + j);
      end
    end
    for (int t = 1; t <= nn; t++) begin
      repeat (opens[t]) exp_tok.push_back(T_OPEN);
      exp_tok.push_back(t);
      repeat (closes[t]) exp_tok.push_back(T_CLOSE);
    end
    for (int a = 1; a <= nn; a++)
      for (int b = nn; b >= a; b--)
        if (internal[a][b]) exp_rd.push_back(a * 32 + b);
  endtask

  // Single compare process: checks every token, read, done and err.
  always @(negedge clk) begin
    int got;
    if (mon_en) begin
      if (start && !busy) begin
        rel = 0;
        stalls = 0;
      end else begin
        rel++;
      end
      if (tok_valid) begin
        if (prev_stall)
          chk({tok_type, tok_idx} == {prev_type, prev_idx}, "stall_stable",
              int'({tok_type, tok_idx}), int'({prev_type, prev_idx}));
        if (tok_ready) begin
          got = int'({tok_type, tok_idx});
          got_q.push_back(got);
          if (exp_tok.size() == 0) chk(1'b0, "extra_token", got, -1);
          else begin
            int e;
            e = exp_tok.pop_front();
            chk(got == e, "token", got, e);
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_type = tok_type;
          prev_idx = tok_idx;
          stalls++;
        end
      end else begin
        if (prev_stall) chk(1'b0, "valid_dropped", 0, 1);
        prev_stall = 1'b0;
      end
      if (s_rd_en) begin
        got = int'(s_rd_i) * 32 + int'(s_rd_j);
        got_rd.push_back(got);
        if (exp_rd.size() == 0) chk(1'b0, "extra_read", got, -1);
        else begin
          int e;
          e = exp_rd.pop_front();
          chk(got == e, "read_addr", got, e);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk(exp_done, "unexpected_done", 1, 0);
        if (exp_done) chk(rel == 8 * cur_n - 4 + stalls, "done_cycle", rel, 8 * cur_n - 4 + stalls);
      end
      if (err) begin
        seen_err = 1'b1;
        chk(exp_err_rel >= 0, "unexpected_err", 1, 0);
        if (exp_err_rel >= 0) chk(rel == exp_err_rel + stalls, "err_cycle", rel, exp_err_rel + stalls);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_start(input int nn);
    @(posedge clk);
    #1;
    start = 1'b1;
    n = IDX_W'(nn);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int c;
    c = 0;
    while (!seen_done && !seen_err && c < 4000) begin
      @(posedge clk);
      c++;
    end
    chk(seen_done || seen_err, {name, "_timeout"}, c, 4000);
    @(negedge clk);
  endtask

  task automatic run_chain(input int nn, input int mode, input string name);
    build_model(nn);
    got_q.delete();
    got_rd.delete();
    seen_done = 1'b0;
    seen_err = 1'b0;
    exp_done = 1'b1;
    exp_err_rel = -1;
    cur_n = nn;
    rdy_mode = mode;
    do_start(nn);
    wait_end(name);
    chk(seen_done, {name, "_done"}, int'(seen_done), 1);
    chk(!seen_err, {name, "_no_err"}, int'(seen_err), 0);
    chk(got_q.size() == 3 * nn - 2, {name, "_tok_count"}, got_q.size(), 3 * nn - 2);
    chk(got_rd.size() == nn - 1, {name, "_read_count"}, got_rd.size(), nn - 1);
    chk(busy == 1'b0, {name, "_busy_low"}, int'(busy), 0);
    $display("txn %s: n=%0d tokens=%0d reads=%0d stalls=%0d", name, nn, got_q.size(), got_rd.size(), stalls);
  endtask

  task automatic check_seq(input string name);
    for (int i = 0; i < want.size(); i++)
      chk(i < got_q.size() && got_q[i] == want[i], name,
          (i < got_q.size()) ? got_q[i] : -1, want[i]);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    n = '0;
    mon_en = 1'b0;
    rdy_mode = 0;
    exp_done = 1'b0;
    exp_err_rel = -1;
    cur_n = 1;
    prev_stall = 1'b0;
    rel = 0;
    stalls = 0;
    clear_tbl();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({busy, done, err, s_rd_en, tok_valid, s_rd_i, s_rd_j, tok_type, tok_idx} == '0,
        "reset_outputs", int'({busy, done, err, s_rd_en, tok_valid, s_rd_i, s_rd_j, tok_type, tok_idx}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // n = 1: single matrix token, no reads.
    clear_tbl();
    run_chain(1, 0, "n1");
    want = {1};
    check_seq("n1_seq");

    // n = 3: M1 (M2 M3).
    clear_tbl();
    tbl[1][3] = 1;
    tbl[2][3] = 2;
    run_chain(3, 0, "n3");
    want = {T_OPEN, 1, T_OPEN, 2, 3, T_CLOSE, T_CLOSE};
    check_seq("n3_seq");
    chk(got_rd.size() == 2 && got_rd[0] == 35 && got_rd[1] == 67, "n3_read_addrs",
        (got_rd.size() > 0) ? got_rd[0] : -1, 35);

    // n = 4 balanced, first with ready high, then with random backpressure.
    clear_tbl();
    tbl[1][4] = 2;
    tbl[1][2] = 1;
    tbl[3][4] = 3;
    run_chain(4, 0, "n4_ready");
    want = {T_OPEN, T_OPEN, 1, 2, T_CLOSE, T_OPEN, 3, 4, T_CLOSE, T_CLOSE};
    check_seq("n4_seq");
    ref_q = got_q;
    run_chain(4, 1, "n4_bp");
    for (int i = 0; i < ref_q.size(); i++)
      chk(i < got_q.size() && got_q[i] == ref_q[i], "n4_bp_vs_ready",
          (i < got_q.size()) ? got_q[i] : -1, ref_q[i]);

    // n = 16, fully left-skewed: deepest stack.
    clear_tbl();
    for (int j = 2; j <= 16; j++) tbl[1][j] = DW'(j - 1);
    run_chain(16, 0, "n16_left");
    want = {};
    repeat (15) want.push_back(T_OPEN);
    want.push_back(1);
    want.push_back(2);
    want.push_back(T_CLOSE);
    check_seq("n16_prefix");

    // Invalid split at the root: err in WAIT (cycle 4), only '(' emitted.
    clear_tbl();
    tbl[1][3] = 3;
    tbl[2][3] = 2;
    exp_tok = {T_OPEN};
    exp_rd = {35};
    got_q.delete();
    got_rd.delete();
    exp_done = 1'b0;
    exp_err_rel = 4;
    cur_n = 3;
    seen_done = 1'b0;
    seen_err = 1'b0;
    rdy_mode = 0;
    do_start(3);
    wait_end("bad_split");
    chk(seen_err, "bad_split_err", int'(seen_err), 1);
    chk(busy == 1'b0, "bad_split_idle", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk(got_q.size() == 1, "bad_split_tok_count", got_q.size(), 1);
    chk(!seen_done, "bad_split_no_done", int'(seen_done), 0);
    $display("txn bad_split: tokens=%0d err=%0d", got_q.size(), seen_err);

    // Rejected starts.
    for (int t = 0; t < 2; t++) begin
      int bad_n;
      bad_n = (t == 0) ? 0 : 17;
      seen_err = 1'b0;
      seen_done = 1'b0;
      exp_done = 1'b0;
      exp_err_rel = 0;
      do_start(bad_n);
      @(negedge clk);
      chk(seen_err, "reject_err", int'(seen_err), 1);
      chk(busy == 1'b0, "reject_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk(busy == 1'b0 && !seen_done, "reject_stays_idle", int'(busy), 0);
      $display("txn reject: n=%0d err=%0d busy=%0d", bad_n, seen_err, busy);
    end

    // Reset while a token is stalled, then a clean n = 2 run.
    mon_en = 1'b0;
    exp_err_rel = -1;
    rdy_mode = 2;
    clear_tbl();
    tbl[1][3] = 1;
    tbl[2][3] = 2;
    do_start(3);
    begin
      int c;
      c = 0;
      while (!tok_valid && c < 50) begin
        @(negedge clk);
        c++;
      end
    end
    repeat (2) @(negedge clk);
    chk(tok_valid && tok_type == 2'b01, "stalled_open", int'({tok_valid, tok_type}), 5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({busy, done, err, s_rd_en, tok_valid, s_rd_i, s_rd_j, tok_type, tok_idx} == '0,
        "reset_abort", int'({busy, done, err, s_rd_en, tok_valid, s_rd_i, s_rd_j, tok_type, tok_idx}), 0);
    $display("txn reset_abort: tok_valid=%0d busy=%0d", tok_valid, busy);
    rdy_mode = 0;
    @(negedge clk);
    mon_en = 1'b1;
    clear_tbl();
    tbl[1][2] = 1;
    run_chain(2, 0, "n2_after_reset");
    want = {T_OPEN, 1, 2, T_CLOSE};
    check_seq("n2_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
